controle_servo_multi: RTL and testbench

//  N-channel hobby-servo PWM generator. One shared period counter; each channel's

---
 rtl/controle_servo_multi.sv | 148 ++++++++++++++
 tb/tb_controle_servo_multi.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_servo_multi.sv
// controle_servo_multi
//   N-channel hobby-servo PWM generator. A single period counter is shared by
//   all channels; channel i drives its output high for
//   MIN_PULSE + active[i]*STEP clocks at the start of every period.
//   Writes land in a pending register and are copied to the active register
//   only when the counter wraps, so a pulse already in progress is never cut
//   short or stretched.
//
//   Build option: define SERVO_SLEW_EN to make each active position step one
//   code per period toward its pending value (em_movimento reports motion).
//   Without it active jumps straight to pending and em_movimento is 0.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous reset, active low
//   load         in   write strobe, one clock per write
//   canal        in   target channel of the write
//   posicao      in   position code to write
//   controle     out  PWM outputs, bit i = channel i
//   periodo_fim  out  one-clock pulse following the last count of each period
//   em_movimento out  some channel still slewing (slew build only)
//   db_reset     out  high while reset is asserted
//   db_controle  out  PWM output of channel DB_CANAL
//   db_posicao   out  active position of channel DB_CANAL
module controle_servo_multi #(
    parameter int unsigned N_CANAIS  = 2,
    parameter int unsigned POS_W     = 3,
    parameter int unsigned PERIODO   = 1000000,
    parameter int unsigned MIN_PULSE = 50000,
    parameter int unsigned STEP      = 7143,
    parameter int unsigned RESET_POS = 0,
    parameter int unsigned DB_CANAL  = 0,
    localparam int unsigned CANAL_W  = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [CANAL_W-1:0]  canal,
    input  logic [POS_W-1:0]    posicao,
    output logic [N_CANAIS-1:0] controle,
    output logic                periodo_fim,
    output logic                em_movimento,
    output logic                db_reset,
    output logic                db_controle,
    output logic [POS_W-1:0]    db_posicao
);

    // Widest possible pulse must leave at least one low clock per period;
    // otherwise the outputs are held constantly high.
    localparam longint unsigned MAX_WIDTH =
        64'(MIN_PULSE) + ((64'd1 << POS_W) - 64'd1) * 64'(STEP);
    localparam bit PARAM_OK = (MAX_WIDTH <= (64'(PERIODO) - 64'd1));

    localparam logic [POS_W-1:0] RST_POS = POS_W'(RESET_POS);
    localparam logic [POS_W-1:0] UM      = POS_W'(1);

    logic [31:0]      cnt;
    logic [POS_W-1:0] pending    [N_CANAIS];
    logic [POS_W-1:0] active     [N_CANAIS];
    logic [POS_W-1:0] nxt_active [N_CANAIS];
    logic [31:0]      width      [N_CANAIS];
    logic [N_CANAIS-1:0] nxt_controle;
    logic             fim_cnt;
    logic             carga_ok;

    assign fim_cnt  = (cnt == PERIODO - 1);
    assign carga_ok = load && (32'(canal) < N_CANAIS);

    always_comb begin
        nxt_controle = '0;
        for (int unsigned i = 0; i < N_CANAIS; i++) begin
            width[i]        = 32'(MIN_PULSE) + 32'(active[i]) * 32'(STEP);
            nxt_controle[i] = PARAM_OK ? (cnt < width[i]) : 1'b1;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_CANAIS; i++) begin
            nxt_active[i] = active[i];
`ifdef SERVO_SLEW_EN
            if (active[i] < pending[i]) begin
                nxt_active[i] = active[i] + UM;
            end else if (active[i] > pending[i]) begin
                nxt_active[i] = active[i] - UM;
            end
`else
            nxt_active[i] = pending[i];
`endif
        end
    end

`ifdef SERVO_SLEW_EN
    logic em_mov_q;
    logic em_mov_d;

    always_comb begin
        em_mov_d = 1'b0;
        for (int unsigned i = 0; i < N_CANAIS; i++) begin
            if (active[i] != pending[i]) begin
                em_mov_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            em_mov_q <= 1'b0;
        end else begin
            em_mov_q <= em_mov_d;
        end
    end

    assign em_movimento = em_mov_q;
`else
    assign em_movimento = 1'b0;
`endif

    // Apply and load share an edge: active takes the old pending value while
    // pending captures the new write, so that write lands one period later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            controle    <= '0;
            periodo_fim <= 1'b0;
            for (int unsigned i = 0; i < N_CANAIS; i++) begin
                pending[i] <= RST_POS;
                active[i]  <= RST_POS;
            end
        end else begin
            cnt         <= fim_cnt ? '0 : cnt + 32'd1;
            periodo_fim <= fim_cnt;
            controle    <= nxt_controle;
            if (fim_cnt) begin
                for (int unsigned i = 0; i < N_CANAIS; i++) begin
                    active[i] <= nxt_active[i];
                end
            end
            if (carga_ok) begin
                pending[canal] <= posicao;
            end
        end
    end

    assign db_reset    = ~reset;
    assign db_controle = controle[DB_CANAL];
    assign db_posicao  = active[DB_CANAL];

endmodule

// File: tb/tb_controle_servo_multi.sv
module tb_controle_servo_multi;

    localparam int unsigned PER  = 100;
    localparam int unsigned MINP = 10;
    localparam int unsigned STP  = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [0:0] canal = '0;
    logic [2:0] posicao = '0;
    logic [1:0] controle;
    logic       periodo_fim, em_movimento, db_reset, db_controle;
    logic [2:0] db_posicao;

    logic       load3 = 1'b0;
    logic [1:0] canal3 = '0;
    logic [2:0] posicao3 = '0;
    logic [2:0] controle3;
    logic       pf3, em3, dbr3, dbc3;
    logic [2:0] dbp3;

    always #5 clock = ~clock;

    controle_servo_multi #(.N_CANAIS(2), .POS_W(3), .PERIODO(PER),
        .MIN_PULSE(MINP), .STEP(STP), .RESET_POS(0), .DB_CANAL(0)) dut (
        .clock(clock), .reset(reset), .load(load), .canal(canal),
        .posicao(posicao), .controle(controle), .periodo_fim(periodo_fim),
        .em_movimento(em_movimento), .db_reset(db_reset),
        .db_controle(db_controle), .db_posicao(db_posicao));

    controle_servo_multi #(.N_CANAIS(3), .POS_W(3), .PERIODO(PER),
        .MIN_PULSE(MINP), .STEP(STP), .RESET_POS(0), .DB_CANAL(2)) dut3 (
        .clock(clock), .reset(reset), .load(load3), .canal(canal3),
        .posicao(posicao3), .controle(controle3), .periodo_fim(pf3),
        .em_movimento(em3), .db_reset(dbr3),
        .db_controle(dbc3), .db_posicao(dbp3));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_pf(input bit sel3, input int lim, output bit ok);
        int n;
        n = 0;
        while (!(sel3 ? pf3 : periodo_fim) && n < lim) begin
            @(negedge clock);
            n++;
        end
        ok = sel3 ? pf3 : periodo_fim;
    endtask

    // ---------------- scoreboard + monitor (main DUT) ----------------
    typedef struct {
        int w0;
        int w1;
        int dbp;
    } exp_t;
    exp_t sb[$];

    bit mon_en = 1'b0;
    bit mon_started = 1'b0;
    int m_len, m_h0, m_h1, m_hd, m_he, m_dbp;

    always @(negedge clock) begin
        exp_t e;
        if (!mon_en) begin
            mon_started = 1'b0;
        end else begin
            if (periodo_fim) begin
                if (mon_started) begin
                    if (sb.size() == 0) begin
                        chk("scoreboard_empty", 0, 1);
                    end else begin
                        e = sb.pop_front();
                        chk("period_len", m_len, int'(PER));
                        chk("width_ch0", m_h0, e.w0);
                        chk("width_ch1", m_h1, e.w1);
                        chk("db_controle_width", m_hd, e.w0);
                        chk("db_posicao", m_dbp, e.dbp);
                        chk("em_movimento_hi", m_he, 0);
                    end
                end
                mon_started = 1'b1;
                m_len = 0; m_h0 = 0; m_h1 = 0; m_hd = 0; m_he = 0;
            end
            if (mon_started) begin
                m_len++;
                m_h0 += int'(controle[0]);
                m_h1 += int'(controle[1]);
                m_hd += int'(db_controle);
                m_he += int'(em_movimento);
                if (m_len == 50) m_dbp = int'(db_posicao);
            end
        end
    end

    // one period on the main DUT starting at a periodo_fim sample
    task automatic run_period(input bit l, input logic [0:0] c, input logic [2:0] p,
                              input int o, output int h0, output int h1, output int he);
        h0 = 0; h1 = 0; he = 0;
        for (int k = 0; k < int'(PER); k++) begin
            h0 += int'(controle[0]);
            h1 += int'(controle[1]);
            he += int'(em_movimento);
            load = l && (k == o);
            canal = c;
            posicao = p;
            @(negedge clock);
        end
        load = 1'b0;
    endtask

    task automatic run3(input bit l, input logic [1:0] c, input logic [2:0] p,
                        input int o, output int h0, output int h1, output int h2,
                        output int dbp);
        h0 = 0; h1 = 0; h2 = 0; dbp = 0;
        for (int k = 0; k < int'(PER); k++) begin
            h0 += int'(controle3[0]);
            h1 += int'(controle3[1]);
            h2 += int'(controle3[2]);
            if (k == 50) dbp = int'(dbp3);
            load3 = l && (k == o);
            canal3 = c;
            posicao3 = p;
            @(negedge clock);
        end
        load3 = 1'b0;
    endtask

`ifndef SERVO_SLEW_EN
    typedef struct {
        bit l1; logic [0:0] c1; logic [2:0] p1; int o1;
        bit l2; logic [0:0] c2; logic [2:0] p2; int o2;
        int w0; int w1; int dbp;
    } vec_t;
    vec_t tbl[10];
`endif

    initial begin
        bit ok;
        int h0, h1, h2, he, dbp, n;

        // reset state
        repeat (2) @(negedge clock);
        chk("rst_controle", int'(controle), 0);
        chk("rst_periodo_fim", int'(periodo_fim), 0);
        chk("rst_em_movimento", int'(em_movimento), 0);
        chk("rst_db_reset", int'(db_reset), 1);
        chk("rst_db_posicao", int'(db_posicao), 0);
        reset = 1'b1;

`ifndef SERVO_SLEW_EN
        //         l1 c1 p1 o1   l2 c2 p2 o2   w0  w1 dbp
        tbl[0] = '{0, 0, 0, 0,   0, 0, 0, 0,   10, 10, 0};
        tbl[1] = '{0, 0, 0, 0,   0, 0, 0, 0,   10, 10, 0};
        tbl[2] = '{1, 1, 4, 40,  0, 0, 0, 0,   10, 10, 0};
        tbl[3] = '{0, 0, 0, 0,   0, 0, 0, 0,   10, 30, 0};
        tbl[4] = '{1, 0, 7, 99,  0, 0, 0, 0,   10, 30, 0};
        tbl[5] = '{0, 0, 0, 0,   0, 0, 0, 0,   10, 30, 0};
        tbl[6] = '{1, 1, 2, 10,  1, 1, 5, 11,  45, 30, 7};
        tbl[7] = '{0, 0, 0, 0,   0, 0, 0, 0,   45, 35, 7};
        tbl[8] = '{1, 0, 0, 0,   0, 0, 0, 0,   45, 35, 7};
        tbl[9] = '{0, 0, 0, 0,   0, 0, 0, 0,   10, 35, 0};

        mon_en = 1'b1;
        for (int r = 0; r < 10; r++) begin
            exp_t e;
            wait_pf(1'b0, 300, ok);
            chk("pf_at_row_start", int'(ok), 1);
            e.w0 = tbl[r].w0; e.w1 = tbl[r].w1; e.dbp = tbl[r].dbp;
            sb.push_back(e);
            for (int k = 0; k < int'(PER); k++) begin
                load = 1'b0;
                if (tbl[r].l1 && k == tbl[r].o1) begin
                    load = 1'b1; canal = tbl[r].c1; posicao = tbl[r].p1;
                end
                if (tbl[r].l2 && k == tbl[r].o2) begin
                    load = 1'b1; canal = tbl[r].c2; posicao = tbl[r].p2;
                end
                @(negedge clock);
            end
            load = 1'b0;
        end
        @(negedge clock);
        #1;
        mon_en = 1'b0;
        chk("scoreboard_drained", sb.size(), 0);
`else
        // slew: ch0 0 -> 3 steps one code per period
        wait_pf(1'b0, 300, ok);
        chk("slew_pf", int'(ok), 1);
        run_period(1'b1, 1'b0, 3'd3, 30, h0, h1, he);
        chk("slew_p0_w0", h0, 10);
        chk("slew_p0_em", he, 68);
        run_period(1'b0, 1'b0, 3'd0, 0, h0, h1, he);
        chk("slew_p1_w0", h0, 15);
        chk("slew_p1_w1", h1, 10);
        chk("slew_p1_em", he, 100);
        run_period(1'b0, 1'b0, 3'd0, 0, h0, h1, he);
        chk("slew_p2_w0", h0, 20);
        chk("slew_p2_em", he, 100);
        run_period(1'b0, 1'b0, 3'd0, 0, h0, h1, he);
        chk("slew_p3_w0", h0, 25);
        chk("slew_p3_em", he, 1);
        run_period(1'b0, 1'b0, 3'd0, 0, h0, h1, he);
        chk("slew_p4_w0", h0, 25);
        chk("slew_p4_em", he, 0);
`endif

        // out-of-range channel on the three-channel instance
        wait_pf(1'b1, 300, ok);
        chk("oor_pf", int'(ok), 1);
        run3(1'b1, 2'd3, 3'd7, 20, h0, h1, h2, dbp);
        run3(1'b1, 2'd2, 3'd1, 50, h0, h1, h2, dbp);
        chk("oor_w0", h0, 10);
        chk("oor_w1", h1, 10);
        chk("oor_w2", h2, 10);
        chk("oor_dbp", dbp, 0);
        run3(1'b0, 2'd0, 3'd0, 0, h0, h1, h2, dbp);
        chk("ch2_w0", h0, 10);
        chk("ch2_w1", h1, 10);
        chk("ch2_w2", h2, 15);
        chk("ch2_dbp", dbp, 1);

        // reset mid-pulse
        wait_pf(1'b0, 300, ok);
        chk("rstmid_pf", int'(ok), 1);
        repeat (5) @(negedge clock);
        chk("rstmid_high_before", int'(controle), 3);
        reset = 1'b0;
        #1;
        chk("rstmid_controle", int'(controle), 0);
        chk("rstmid_controle3", int'(controle3), 0);
        chk("rstmid_db_reset", int'(db_reset), 1);
        chk("rstmid_db_controle", int'(db_controle), 0);
        chk("rstmid_pf_low", int'(periodo_fim), 0);
        @(negedge clock);
        chk("rstmid_held", int'(controle), 0);
        reset = 1'b1;
        #1;
        chk("rel_db_reset", int'(db_reset), 0);
        n = 0; h0 = 0; h1 = 0;
        while (n < 300) begin
            @(negedge clock);
            n++;
            if (periodo_fim) break;
            h0 += int'(controle[0]);
            h1 += int'(controle[1]);
        end
        chk("rel_first_pf", n, int'(PER));
        chk("rel_w0", h0, 10);
        chk("rel_w1", h1, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
